// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg: shared state encoding and guard length for the serial transmit arbiter
package serial_arb_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GUARD, DRAIN} state_t;
  localparam int GUARD_CYCLES = 2;
endpackage

// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if: requester byte streams plus the transmitter data/strobe/busy link
interface serial_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic [7:0] tx_data;
  logic new_tx_data;
  logic tx_busy;
  modport master(output req_valid, req_data, req_last, tx_busy, input req_ready, tx_data, new_tx_data);
  modport slave(input req_valid, req_data, req_last, tx_busy, output req_ready, tx_data, new_tx_data);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational cyclic first-set search starting at the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int PW = $clog2(NUM_REQ);
  assign any = |req;
  // scanning from the farthest offset down lets the nearest request overwrite
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_REQ]) idx = PW'((int'(ptr) + i) % NUM_REQ);
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: packet-locked round-robin sharing of one serial transmitter,
// paced by the transmitter busy flag, with a watchdog that revokes stalled locks.
module serial_tx_arbiter
  import serial_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       link_ready,
  serial_tx_arbiter_if.slave         bus,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = LOCK_TIMEOUT > 0 ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  state_t state;
  logic [PW-1:0] ptr, win, nxt;
  logic [WW-1:0] wdog;
  logic [GW-1:0] guard_cnt;
  logic any, last_r, xfer, idle_tick, wd_hit;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(bus.req_valid), .ptr(ptr), .any(any), .idx(win));
  always_comb begin
    xfer = state == SEND && !bus.tx_busy && bus.req_valid[grant_id];
    idle_tick = state == SEND && !bus.req_valid[grant_id];
    wd_hit = LOCK_TIMEOUT != 0 && idle_tick && wdog == WW'(LOCK_TIMEOUT - 1);
    nxt = grant_id == PW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    bus.req_ready = state == SEND && !bus.tx_busy ? NUM_REQ'(1) << grant_id : '0;
  end
  // the transmitter is never aborted; a revoked lock only frees the arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
      last_r <= 1'b0;
      guard_cnt <= '0;
      wdog <= '0;
      bus.tx_data <= '0;
      bus.new_tx_data <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      bus.new_tx_data <= xfer;
      timeout_err <= wd_hit;
      case (state)
        IDLE: if (link_ready && any) begin
          grant_id <= win;
          grant_valid <= 1'b1;
          wdog <= '0;
          state <= SEND;
        end
        SEND: if (xfer) begin
          bus.tx_data <= bus.req_data[{grant_id, 3'b000} +: 8];
          last_r <= bus.req_last[grant_id];
          wdog <= '0;
          guard_cnt <= '0;
          state <= GUARD;
        end else if (wd_hit) begin
          wdog <= '0;
          ptr <= nxt;
          grant_valid <= 1'b0;
          state <= IDLE;
        end else if (idle_tick) begin
          wdog <= wdog + 1'b1;
        end
        GUARD: begin
          guard_cnt <= guard_cnt + 1'b1;
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) state <= DRAIN;
        end
        DRAIN: if (!bus.tx_busy) begin
          if (last_r) begin
            ptr <= nxt;
            grant_valid <= 1'b0;
            state <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed scenarios against table-driven requesters and a busy-pulse transmitter model
module tb_serial_tx_arbiter;
  import serial_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic link_ready = 1'b1;
  logic grant_valid, timeout_err;
  logic [1:0] grant_id;
  serial_tx_arbiter_if #(.NUM_REQ(4)) bus ();
  serial_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .link_ready(link_ready), .bus(bus),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int busy_len = 1;
  int busy_cnt = 0;
  always @(posedge clk) busy_cnt <= bus.new_tx_data ? busy_len : (busy_cnt > 0 ? busy_cnt - 1 : 0);
  assign bus.tx_busy = busy_cnt != 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] sd [4][8];
  bit sl [4][8];
  int slen [4];
  int sidx [4];
  int rdy_cyc [4];
  bit fire [4];
  logic [7:0] log_d [$];
  int log_c [$];
  int log_g [$];
  int to_n, to_cyc, multi_rdy;

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      slen[i] = 0;
      sidx[i] = 0;
      fire[i] = 0;
      rdy_cyc[i] = -1;
    end
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    log_d.delete();
    log_c.delete();
    log_g.delete();
    to_n = 0;
    to_cyc = -1;
    multi_rdy = 0;
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base, input logic [7:0] inc, input bit each, input bit fin);
    for (int j = 0; j < n; j++) begin
      sd[r][j] = base + 8'(j) * inc;
      sl[r][j] = (j == n - 1) ? fin : each;
    end
    slen[r] = n;
  endtask

  task automatic step();
    logic v;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) sidx[i]++;
      v = sidx[i] < slen[i];
      bus.req_valid[i] = v;
      bus.req_data[8*i +: 8] = v ? sd[i][sidx[i]] : 8'h00;
      bus.req_last[i] = v && sl[i][sidx[i]];
    end
    if (bus.new_tx_data) begin
      log_d.push_back(bus.tx_data);
      log_c.push_back(cyc);
      log_g.push_back(int'(grant_id));
    end
    if (timeout_err) begin
      to_n++;
      to_cyc = cyc;
    end
    if ($countones(bus.req_ready) > 1) multi_rdy++;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_ready[i] && rdy_cyc[i] < 0) rdy_cyc[i] = cyc;
      fire[i] = bus.req_valid[i] && bus.req_ready[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    link_ready = 1'b1;
    do_reset();
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %0h want 0", bus.tx_data); end
    n_cmp++; if (bus.new_tx_data !== 1'b0) begin n_bad++; $display("FAIL reset_new_tx_data: got %0b want 0", bus.new_tx_data); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %0b want 0", bus.req_ready); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_grant_valid: got %0b want 0", grant_valid); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_d [3] = '{8'hA1, 8'hA2, 8'hA3};
    busy_len = 10;
    do_reset();
    load(1, 3, 8'hA1, 8'h01, 0, 1);
    repeat (50) step();
    n_cmp++;
    if (log_d.size() != 3) begin
      n_bad++; $display("FAIL single_count: got %0d strobes want 3", log_d.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (log_d[k] !== exp_d[k]) begin n_bad++; $display("FAIL single_byte%0d: got %0h want %0h", k, log_d[k], exp_d[k]); end
        n_cmp++; if (log_g[k] != 1) begin n_bad++; $display("FAIL single_gid%0d: got %0d want 1", k, log_g[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        n_cmp++; if (log_c[k] - log_c[k-1] != 13) begin n_bad++; $display("FAIL single_period%0d: got %0d want 13", k, log_c[k] - log_c[k-1]); end
      end
    end
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL single_release: got %0b want 0", grant_valid); end
    n_cmp++; if (to_n != 0) begin n_bad++; $display("FAIL single_no_timeout: got %0d want 0", to_n); end
  endtask

  task automatic test_min_period();
    busy_len = 1;
    do_reset();
    load(1, 3, 8'hC0, 8'h01, 0, 1);
    repeat (30) step();
    n_cmp++;
    if (log_d.size() != 3) begin
      n_bad++; $display("FAIL minper_count: got %0d want 3", log_d.size());
    end else begin
      n_cmp++; if (log_c[1] - log_c[0] != 4) begin n_bad++; $display("FAIL minper_period: got %0d want 4", log_c[1] - log_c[0]); end
      n_cmp++; if (log_d[2] !== 8'hC2) begin n_bad++; $display("FAIL minper_byte2: got %0h want c2", log_d[2]); end
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h20, 8'h21};
    busy_len = 3;
    do_reset();
    load(0, 2, 8'h10, 8'h01, 0, 1);
    load(2, 2, 8'h20, 8'h01, 0, 1);
    repeat (60) step();
    n_cmp++;
    if (log_d.size() != 4) begin
      n_bad++; $display("FAIL contend_count: got %0d want 4", log_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (log_d[k] !== exp_d[k]) begin n_bad++; $display("FAIL contend_byte%0d: got %0h want %0h", k, log_d[k], exp_d[k]); end
      end
      n_cmp++; if (rdy_cyc[2] <= log_c[1]) begin n_bad++; $display("FAIL contend_ready2_early: got cycle %0d want after %0d", rdy_cyc[2], log_c[1]); end
    end
    n_cmp++; if (multi_rdy != 0) begin n_bad++; $display("FAIL contend_multi_ready: got %0d want 0", multi_rdy); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_d [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};
    busy_len = 1;
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 2, 8'(i), 8'h10, 1, 1);
    repeat (80) step();
    n_cmp++;
    if (log_d.size() != 8) begin
      n_bad++; $display("FAIL fair_count: got %0d want 8", log_d.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++; if (log_d[k] !== exp_d[k]) begin n_bad++; $display("FAIL fair_order%0d: got %0h want %0h", k, log_d[k], exp_d[k]); end
      end
    end
    n_cmp++; if (multi_rdy != 0) begin n_bad++; $display("FAIL fair_multi_ready: got %0d want 0", multi_rdy); end
  endtask

  task automatic test_watchdog();
    busy_len = 10;
    do_reset();
    load(0, 1, 8'h55, 8'h00, 0, 0);
    load(3, 1, 8'h3C, 8'h00, 1, 1);
    repeat (60) step();
    n_cmp++; if (to_n != 1) begin n_bad++; $display("FAIL wd_pulses: got %0d want 1", to_n); end
    n_cmp++;
    if (log_d.size() != 2) begin
      n_bad++; $display("FAIL wd_count: got %0d want 2", log_d.size());
    end else begin
      n_cmp++; if (log_d[0] !== 8'h55) begin n_bad++; $display("FAIL wd_first: got %0h want 55", log_d[0]); end
      n_cmp++; if (to_cyc != log_c[0] + 28) begin n_bad++; $display("FAIL wd_when: got %0d want %0d", to_cyc, log_c[0] + 28); end
      n_cmp++; if (rdy_cyc[3] != to_cyc + 1) begin n_bad++; $display("FAIL wd_regrant: got %0d want %0d", rdy_cyc[3], to_cyc + 1); end
      n_cmp++; if (log_d[1] !== 8'h3C || log_g[1] != 3) begin n_bad++; $display("FAIL wd_next: got %0h/%0d want 3c/3", log_d[1], log_g[1]); end
    end
  endtask

  task automatic test_link_gating();
    int c;
    busy_len = 1;
    link_ready = 1'b0;
    do_reset();
    load(2, 1, 8'h77, 8'h00, 1, 1);
    repeat (50) step();
    n_cmp++; if (rdy_cyc[2] != -1 || grant_valid !== 1'b0) begin n_bad++; $display("FAIL link_blocked: got ready cycle %0d gv %0b want -1/0", rdy_cyc[2], grant_valid); end
    link_ready = 1'b1;
    c = cyc;
    repeat (10) step();
    n_cmp++; if (rdy_cyc[2] != c + 1) begin n_bad++; $display("FAIL link_grant: got %0d want %0d", rdy_cyc[2], c + 1); end
    n_cmp++; if (log_d.size() != 1 || (log_d.size() == 1 && log_d[0] !== 8'h77)) begin n_bad++; $display("FAIL link_byte: got %0d strobes want one 77", log_d.size()); end
  endtask

  task automatic test_reset_mid_packet();
    busy_len = 10;
    do_reset();
    load(1, 2, 8'h90, 8'h01, 0, 1);
    for (int t = 0; t < 20 && log_d.size() == 0; t++) step();
    n_cmp++; if (log_d.size() != 1 || dut.state !== GUARD) begin n_bad++; $display("FAIL rmid_setup: got %0d strobes state %0d want 1/GUARD", log_d.size(), dut.state); end
    rst = 1'b1;
    step();
    n_cmp++; if (bus.tx_data !== 8'h00 || bus.new_tx_data !== 1'b0 || bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rmid_tx: got %0h/%0b/%0b want 0/0/0", bus.tx_data, bus.new_tx_data, bus.req_ready); end
    n_cmp++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rmid_grant: got %0b/%0d/%0b want 0/0/0", grant_valid, grant_id, timeout_err); end
    n_cmp++; if (dut.state !== IDLE) begin n_bad++; $display("FAIL rmid_state: got %0d want IDLE", dut.state); end
    rst = 1'b0;
    clear_src();
    for (int i = 0; i < 4; i++) load(i, 1, 8'hB0 + 8'(i), 8'h00, 1, 1);
    repeat (40) step();
    n_cmp++;
    if (log_d.size() == 0) begin
      n_bad++; $display("FAIL rmid_regrant: got no strobe want b0");
    end else if (log_d[0] !== 8'hB0 || log_g[0] != 0) begin
      n_bad++; $display("FAIL rmid_regrant: got %0h/%0d want b0/0", log_d[0], log_g[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_min_period();
    test_contention();
    test_fairness();
    test_watchdog();
    test_link_gating();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
